taxi_fare: RTL and testbench
============================

TAXI_FARE -- requirements
Module: taxi_fare

Interface
REQ-001 SHALL have parameter BASE_FARE, default 100, meaning the flag-fall fare in units of 0.1 currency.
REQ-002 SHALL have parameter BASE_KM, default 3, meaning the number of kilometres included in the base fare.
REQ-003 SHALL have parameter PER_KM, default 20, meaning the fare added per kilometre beyond BASE_KM.
REQ-004 SHALL have parameter WAIT_SEC, default 60, meaning the number of wait seconds per waiting charge.
REQ-005 SHALL have parameter PER_WAIT, default 10, meaning the fare added per completed WAIT_SEC interval.
REQ-006 SHALL have parameter FARE_MAX, default 9999, meaning the fare saturation ceiling.
REQ-007 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-009 SHALL have port start, input, 1 bit: passenger boards; begins a trip.
REQ-010 SHALL have port stop, input, 1 bit: trip ends; freezes the fare.
REQ-011 SHALL have port clear, input, 1 bit: driver clears the display and returns to idle.
REQ-012 SHALL have port km_co, input, 1 bit: one-cycle pulse per completed kilometre, from the distance meter carry output.
REQ-013 SHALL have port wait_tick, input, 1 bit: one-cycle pulse per second while the vehicle is stationary.
REQ-014 SHALL have port fare, output, 14 bits: current fare in units of 0.1 currency.
REQ-015 SHALL have port km_total, output, 11 bits: kilometres in the current trip, saturating at 2047.
REQ-016 SHALL have port state, output, 2 bits: FSM state encoded as IDLE=0, RUN=1, DONE=2.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse on the RUN->DONE transition.

Function
REQ-018 FSM SHALL transition IDLE->RUN on start; on entry, fare=BASE_FARE, km_total=0, wait count=0.
REQ-019 RUN SHALL transition to DONE on stop; done=1 for exactly that one cycle; fare and km_total then frozen.
REQ-020 DONE SHALL transition to RUN on start, with the same reload as REQ-018; DONE->IDLE on clear (fare=0, km_total=0).
REQ-021 RUN->IDLE on clear SHALL abort the trip without pulsing done.
REQ-022 Priority within one cycle SHALL be clear > stop > start.
REQ-023 start while in RUN SHALL be ignored.
REQ-024 km_co and wait_tick SHALL be ignored outside RUN.
REQ-025 In RUN, each km_co SHALL increment km_total; if the pre-increment km_total >= BASE_KM, fare SHALL increase by PER_KM, registered on the next edge.
REQ-026 In RUN, each wait_tick SHALL increment the wait counter (0..WAIT_SEC-1); on wrap from WAIT_SEC-1 to 0, fare SHALL increase by PER_WAIT.
REQ-027 If km_co and a wait wrap occur in the same cycle, both increments SHALL apply in that cycle, as one sum.
REQ-028 If stop coincides with km_co or wait_tick, that event SHALL be counted before freezing: the DONE fare includes it.
REQ-029 fare SHALL saturate at FARE_MAX and never wrap; km_total SHALL saturate at 2047.
REQ-030 Internal addition SHALL use at least 15 bits so that the overflow is detected before the clamp.
REQ-031 All outputs SHALL be registered, with 1-cycle latency from the input event to the output change.

Reset
REQ-032 On rst=1 at a clk edge: state=IDLE, fare=0, km_total=0, done=0, wait counter=0.
REQ-033 rst SHALL override all other inputs, including mid-trip; no done pulse is generated.

Structure
REQ-034 A shared package taxi_pkg SHALL hold the state enum (IDLE/RUN/DONE), the FARE_W=14 and KM_W=11 width constants, and the default tariff constants.
REQ-035 One sub-module, taxi_wait_timer, SHALL implement the wait_tick counter, producing a one-cycle wrap pulse; it is cleared by rst and on trip start.

Verification
REQ-036 Reset, start, then 3 km_co pulses: fare stays 100 and km_total=3.
REQ-037 Continue with a 4th and 5th km_co: fare=120, then 140; stop: done pulses once; state=2; fare holds 140 for 100 cycles.
REQ-038 In RUN, 119 wait_ticks: fare=110 (one charge); the 120th tick: fare=120. A km_co on the same cycle as the 120th tick (with km_total>=3): fare rises by 30 in one cycle.
REQ-039 Drive the fare toward FARE_MAX with repeated km_co: fare clamps at 9999; km_total increments and never wraps past 2047.
REQ-040 stop and km_co in the same cycle with km_total=4: frozen fare includes +20. clear, stop and start together: state=IDLE, fare=0.
REQ-041 Assert rst mid-trip (fare=140): next cycle all outputs are 0, done=0; km_co in IDLE leaves km_total at 0.

Source files
------------

// File: rtl/taxi_pkg.sv
// Shared types and tariff defaults for the taxi fare meter.
// Fares are in units of 0.1 currency.
package taxi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FARE_W = 14;
    localparam int KM_W   = 11;

    localparam int DEF_BASE_FARE = 100;
    localparam int DEF_BASE_KM   = 3;
    localparam int DEF_PER_KM    = 20;
    localparam int DEF_WAIT_SEC  = 60;
    localparam int DEF_PER_WAIT  = 10;
    localparam int DEF_FARE_MAX  = 9999;

endpackage

// File: rtl/taxi_fare_if.sv
// Control and display signals between the meter and its cab-side logic.
// The meter core uses the slave view.
interface taxi_fare_if;
    import taxi_pkg::*;

    logic              start;
    logic              stop;
    logic              clear;
    logic              km_co;
    logic              wait_tick;
    logic [FARE_W-1:0] fare;
    logic [KM_W-1:0]   km_total;
    state_t            state;
    logic              done;

    modport master (
        output start, stop, clear, km_co, wait_tick,
        input  fare, km_total, state, done
    );

    modport slave (
        input  start, stop, clear, km_co, wait_tick,
        output fare, km_total, state, done
    );

endinterface

// File: rtl/taxi_wait_timer.sv
// Counts wait seconds and flags the tick that completes a charge interval.
// wrap is combinational so the charge lands on the same edge as the tick.
module taxi_wait_timer
    import taxi_pkg::*;
#(
    parameter int WAIT_SEC = DEF_WAIT_SEC
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic tick,
    output logic wrap
);

    localparam int CW = (WAIT_SEC > 1) ? $clog2(WAIT_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(WAIT_SEC - 1);

    logic [CW-1:0] cnt_q;

    assign wrap = tick && (cnt_q == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (wrap) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/taxi_fare.sv
// Taxi meter: trip FSM, distance and waiting charges, saturating fare.
// All outputs are registered; events show up one edge after they occur.
module taxi_fare
    import taxi_pkg::*;
#(
    parameter int BASE_FARE = DEF_BASE_FARE,
    parameter int BASE_KM   = DEF_BASE_KM,
    parameter int PER_KM    = DEF_PER_KM,
    parameter int WAIT_SEC  = DEF_WAIT_SEC,
    parameter int PER_WAIT  = DEF_PER_WAIT,
    parameter int FARE_MAX  = DEF_FARE_MAX
) (
    input logic       clk,
    input logic       rst,
    taxi_fare_if.slave bus
);

    // Two spare bits so the sum can exceed the ceiling before clamping
    localparam int SW = FARE_W + 2;

    localparam logic [SW-1:0]     CEIL    = SW'(FARE_MAX);
    localparam logic [SW-1:0]     KM_INC  = SW'(PER_KM);
    localparam logic [SW-1:0]     WT_INC  = SW'(PER_WAIT);
    localparam logic [FARE_W-1:0] FARE0   = FARE_W'(BASE_FARE);
    localparam logic [FARE_W-1:0] FMAX    = FARE_W'(FARE_MAX);
    localparam logic [KM_W-1:0]   KM_FREE = KM_W'(BASE_KM);
    localparam logic [KM_W-1:0]   KM_SAT  = '1;

    state_t            st_q, st_d;
    logic [FARE_W-1:0] fare_q, fare_d;
    logic [KM_W-1:0]   km_q, km_d;
    logic              done_q, done_d;
    logic              trip_go;
    logic              tick_en;
    logic              wrap;
    logic              km_hit;
    logic [SW-1:0]     sum;

    assign tick_en = bus.wait_tick && (st_q == RUN);

    taxi_wait_timer #(
        .WAIT_SEC (WAIT_SEC)
    ) u_wait (
        .clk  (clk),
        .rst  (rst),
        .clr  (trip_go),
        .tick (tick_en),
        .wrap (wrap)
    );

    always_comb begin
        st_d    = st_q;
        fare_d  = fare_q;
        km_d    = km_q;
        done_d  = 1'b0;
        trip_go = 1'b0;
        km_hit  = bus.km_co && (km_q >= KM_FREE);
        sum     = SW'(fare_q)
                + (km_hit ? KM_INC : '0)
                + (wrap   ? WT_INC : '0);

        unique case (st_q)
            IDLE: begin
                if (!bus.clear && !bus.stop && bus.start) begin
                    st_d    = RUN;
                    fare_d  = FARE0;
                    km_d    = '0;
                    trip_go = 1'b1;
                end
            end
            RUN: begin
                if (bus.clear) begin
                    st_d   = IDLE;
                    fare_d = '0;
                    km_d   = '0;
                end else begin
                    fare_d = (sum > CEIL) ? FMAX : sum[FARE_W-1:0];
                    if (bus.km_co && (km_q != KM_SAT)) begin
                        km_d = km_q + KM_W'(1);
                    end
                    if (bus.stop) begin
                        st_d   = DONE;
                        done_d = 1'b1;
                    end
                end
            end
            DONE: begin
                if (bus.clear) begin
                    st_d   = IDLE;
                    fare_d = '0;
                    km_d   = '0;
                end else if (!bus.stop && bus.start) begin
                    st_d    = RUN;
                    fare_d  = FARE0;
                    km_d    = '0;
                    trip_go = 1'b1;
                end
            end
            default: begin
                st_d   = IDLE;
                fare_d = '0;
                km_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q   <= IDLE;
            fare_q <= '0;
            km_q   <= '0;
            done_q <= 1'b0;
        end else begin
            st_q   <= st_d;
            fare_q <= fare_d;
            km_q   <= km_d;
            done_q <= done_d;
        end
    end

    assign bus.state    = st_q;
    assign bus.fare     = fare_q;
    assign bus.km_total = km_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_taxi_fare.sv
// Bench for taxi_fare: directed trips with literal fares, then random
// traffic checked every cycle against a trip-level reference model.
module tb_taxi_fare;

    localparam int T_BASE  = 100;
    localparam int T_BKM   = 3;
    localparam int T_PKM   = 20;
    localparam int T_WSEC  = 60;
    localparam int T_PWAIT = 10;
    localparam int T_MAX   = 9999;
    localparam int KM_CAP  = 2047;

    logic clk = 1'b0;
    logic rst = 1'b1;

    taxi_fare_if bus ();

    taxi_fare #(
        .BASE_FARE (T_BASE),
        .BASE_KM   (T_BKM),
        .PER_KM    (T_PKM),
        .WAIT_SEC  (T_WSEC),
        .PER_WAIT  (T_PWAIT),
        .FARE_MAX  (T_MAX)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;

    // Reference trip state: 0 idle, 1 running, 2 finished
    int m_st   = 0;
    int m_fare = 0;
    int m_km   = 0;
    int m_wait = 0;
    int m_done = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic cyc(input bit r, input bit s, input bit p,
                       input bit c, input bit k, input bit w);
        rst           = r;
        bus.start     = s;
        bus.stop      = p;
        bus.clear     = c;
        bus.km_co     = k;
        bus.wait_tick = w;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0);
    endtask

    // Reference model plus per-cycle comparison
    initial begin
        int add;
        forever begin
            @(posedge clk);
            m_done = 0;
            if (rst) begin
                m_st = 0; m_fare = 0; m_km = 0; m_wait = 0;
            end else if (bus.clear) begin
                m_st = 0; m_fare = 0; m_km = 0;
            end else if (m_st == 1) begin
                add = 0;
                if (bus.km_co) begin
                    if (m_km >= T_BKM) add += T_PKM;
                    if (m_km < KM_CAP) m_km++;
                end
                if (bus.wait_tick) begin
                    m_wait++;
                    if (m_wait == T_WSEC) begin
                        m_wait = 0;
                        add += T_PWAIT;
                    end
                end
                m_fare = (m_fare + add > T_MAX) ? T_MAX : m_fare + add;
                if (bus.stop) begin
                    m_st = 2;
                    m_done = 1;
                end
            end else if (!bus.stop && bus.start) begin
                m_st = 1; m_fare = T_BASE; m_km = 0; m_wait = 0;
            end
            #1;
            check("state", int'(bus.state), m_st);
            check("fare", int'(bus.fare), m_fare);
            check("km_total", int'(bus.km_total), m_km);
            check("done", int'(bus.done), m_done);
        end
    end

    initial begin
        int dcnt;
        bit r, s, p, c, k, w;

        bus.start = 0; bus.stop = 0; bus.clear = 0;
        bus.km_co = 0; bus.wait_tick = 0;
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("rst_fare", int'(bus.fare), 0);
        check("rst_state", int'(bus.state), 0);
        check("rst_km", int'(bus.km_total), 0);
        check("rst_done", int'(bus.done), 0);

        // Three free kilometres, then two charged ones
        cyc(0, 1, 0, 0, 0, 0);
        check("start_fare", int'(bus.fare), 100);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0, 1, 0);
            idle_n(1);
        end
        check("free_km_fare", int'(bus.fare), 100);
        check("free_km_cnt", int'(bus.km_total), 3);
        cyc(0, 0, 0, 0, 1, 0);
        check("km4_fare", int'(bus.fare), 120);
        cyc(0, 0, 0, 0, 1, 0);
        check("km5_fare", int'(bus.fare), 140);
        cyc(0, 0, 1, 0, 0, 0);
        check("stop_done", int'(bus.done), 1);
        check("stop_state", int'(bus.state), 2);
        dcnt = 0;
        for (int i = 0; i < 100; i++) begin
            cyc(0, 0, 0, 0, i % 3 == 0, i % 2 == 0);
            if (bus.done) dcnt++;
        end
        check("done_after", dcnt, 0);
        check("frozen_fare", int'(bus.fare), 140);

        // Reset mid-trip
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, 0, 1, 0);
        check("pre_rst_fare", int'(bus.fare), 140);
        cyc(1, 0, 0, 0, 0, 0);
        check("mid_rst_fare", int'(bus.fare), 0);
        check("mid_rst_state", int'(bus.state), 0);
        check("mid_rst_done", int'(bus.done), 0);
        cyc(0, 0, 0, 0, 1, 0);
        check("idle_km", int'(bus.km_total), 0);

        // Waiting charges
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 119; i++) cyc(0, 0, 0, 0, 0, 1);
        check("wait119", int'(bus.fare), 110);
        cyc(0, 0, 0, 0, 0, 1);
        check("wait120", int'(bus.fare), 120);
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 119; i++) cyc(0, 0, 0, 0, 0, 1);
        check("wait119b", int'(bus.fare), 110);
        cyc(0, 0, 0, 0, 1, 1);
        check("km_wait_same", int'(bus.fare), 140);

        // Stop with a coincident kilometre, then all controls at once
        cyc(0, 0, 0, 1, 0, 0);
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0);
        check("km4_total", int'(bus.km_total), 4);
        cyc(0, 0, 1, 0, 1, 0);
        check("stop_km_fare", int'(bus.fare), 140);
        check("stop_km_state", int'(bus.state), 2);
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0);
        check("csp_state", int'(bus.state), 0);
        check("csp_fare", int'(bus.fare), 0);

        // Saturation of fare and distance
        cyc(0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2100; i++) cyc(0, 0, 0, 0, 1, 0);
        check("fare_sat", int'(bus.fare), 9999);
        check("km_sat", int'(bus.km_total), 2047);
        cyc(0, 0, 0, 0, 1, 1);
        check("km_sat_hold", int'(bus.km_total), 2047);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            c = ($urandom_range(0, 99) == 0);
            p = ($urandom_range(0, 59) == 0);
            s = ($urandom_range(0, 14) == 0);
            k = ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 1) == 0);
            cyc(r, s, p, c, k, w);
        end
        idle_n(2);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
